mod_dds_seq: RTL and testbench

Segment sequencer for `mod_dds`: accepts (table address, duration) commands, fetches the 256-bit parameter word from the parameter table memory, and drives `mod_dds` parameter input and time base. It counts `t` from 0 to len-1 and chains segments back-to-back through a one-deep prefetch buffer. It sits between the command source (tProcessor-side FIFO) and the `mod_dds` instance.

---
 rtl/mod_dds_pkg.sv | 34 +++
 rtl/mod_dds_seq_if.sv | 13 +
 rtl/mod_dds_fetch.sv | 32 +++
 rtl/mod_dds_seq.sv | 164 ++++++++++++++++
 tb/tb_mod_dds_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_dds_pkg.sv
// Shared types for the mod_dds segment sequencer: parameter word layout and FSM states.
package mod_dds_pkg;

   localparam int unsigned PW     = 256;
   localparam int unsigned FMOD_W = 18;
   localparam int unsigned AMOD_W = 16;
   localparam int unsigned POFF_W = 18;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned USED_W = 7 * FMOD_W + 2 * AMOD_W + POFF_W + CTRL_W;
   localparam int unsigned PAD_W  = PW - USED_W;

   // First member is the MSB; FMOD_C0 sits at bit 0, bits [255:184] are reserved
   typedef struct packed {
      logic [PAD_W-1:0]  pad;
      logic [CTRL_W-1:0] ctrl;
      logic [POFF_W-1:0] poff;
      logic [AMOD_W-1:0] amod_c1;
      logic [AMOD_W-1:0] amod_c0;
      logic [FMOD_W-1:0] fmod_g;
      logic [FMOD_W-1:0] fmod_c5;
      logic [FMOD_W-1:0] fmod_c4;
      logic [FMOD_W-1:0] fmod_c3;
      logic [FMOD_W-1:0] fmod_c2;
      logic [FMOD_W-1:0] fmod_c1;
      logic [FMOD_W-1:0] fmod_c0;
   } par_word_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_RUN
   } state_t;

endpackage

// File: rtl/mod_dds_seq_if.sv
// Command channel (address, duration) from the command FIFO into the sequencer.
interface mod_dds_seq_if #(
   parameter int unsigned AW = 10,
   parameter int unsigned BT = 16
) ();
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [BT-1:0] cmd_len;

   modport master (output cmd_valid, cmd_addr, cmd_len, input cmd_ready);
   modport slave  (input cmd_valid, cmd_addr, cmd_len, output cmd_ready);
endinterface

// File: rtl/mod_dds_fetch.sv
// Tracks outstanding table reads: a MEM_LAT-deep valid/tag pipe aligned with mem_dout.
module mod_dds_fetch #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_flush,
   input  logic i_vld,
   input  logic i_tag,
   output logic o_vld,
   output logic o_tag
);
   logic [MEM_LAT-1:0] r_vld;
   logic [MEM_LAT-1:0] r_tag;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_vld <= '0;
         r_tag <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_tag[0] <= i_tag;
         for (int i = 1; i < MEM_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign o_vld = r_vld[MEM_LAT-1];
   assign o_tag = r_tag[MEM_LAT-1];
endmodule

// File: rtl/mod_dds_seq.sv
// Segment sequencer: fetches parameter words, runs the time base per segment and
// chains segments through a one-deep shadow slot.
module mod_dds_seq
   import mod_dds_pkg::*;
#(
   parameter int unsigned BT      = 16,
   parameter int unsigned AW      = 10,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   mod_dds_seq_if.slave     cmd,
   input  logic             stop,
   output logic [AW-1:0]    mem_addr,
   input  logic [PW-1:0]    mem_dout,
   output logic [PW-1:0]    par_dout,
   output logic [BT-1:0]    t_out,
   output logic             busy,
   output logic             done
);
   state_t        r_state, w_state_n;
   par_word_t     r_par, w_par_n, r_sh_word, w_sh_word_n, w_mem_word;
   logic [BT-1:0] r_t, w_t_n, r_len, w_len_n, r_sh_len, w_sh_len_n;
   logic          r_sh_full, w_sh_full_n, r_sh_vld, w_sh_vld_n;
   logic [AW-1:0] r_mem_addr, w_mem_addr_n;
   logic          r_iss, w_iss_n, r_iss_tag, w_iss_tag_n;
   logic          r_busy, r_done, w_done_n;
   logic          w_ready, w_acc, w_last, w_ret_vld, w_ret_tag;

   // Ready depends on stop in the same cycle, so it cannot be registered
   assign w_ready    = ~rst & ~stop &
                       ((r_state == S_IDLE) | ((r_state == S_RUN) & ~r_sh_full));
   assign w_acc      = cmd.cmd_valid & w_ready & (cmd.cmd_len != '0);
   assign w_last     = (r_state == S_RUN) & (r_t == r_len - BT'(1));
   assign w_mem_word = par_word_t'(mem_dout);

   mod_dds_fetch #(.MEM_LAT(MEM_LAT)) u_fetch (
      .clk     (clk),
      .rst     (rst),
      .i_flush (stop),
      .i_vld   (r_iss),
      .i_tag   (r_iss_tag),
      .o_vld   (w_ret_vld),
      .o_tag   (w_ret_tag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_par      <= '0;
         r_t        <= '0;
         r_len      <= '0;
         r_sh_full  <= 1'b0;
         r_sh_vld   <= 1'b0;
         r_sh_word  <= '0;
         r_sh_len   <= '0;
         r_mem_addr <= '0;
         r_iss      <= 1'b0;
         r_iss_tag  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_par      <= w_par_n;
         r_t        <= w_t_n;
         r_len      <= w_len_n;
         r_sh_full  <= w_sh_full_n;
         r_sh_vld   <= w_sh_vld_n;
         r_sh_word  <= w_sh_word_n;
         r_sh_len   <= w_sh_len_n;
         r_mem_addr <= w_mem_addr_n;
         r_iss      <= w_iss_n;
         r_iss_tag  <= w_iss_tag_n;
         r_busy     <= (w_state_n != S_IDLE);
         r_done     <= w_done_n;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_par_n      = r_par;
      w_t_n        = r_t;
      w_len_n      = r_len;
      w_sh_full_n  = r_sh_full;
      w_sh_vld_n   = r_sh_vld;
      w_sh_word_n  = r_sh_word;
      w_sh_len_n   = r_sh_len;
      w_mem_addr_n = w_acc ? cmd.cmd_addr : r_mem_addr;
      w_iss_n      = w_acc;
      w_iss_tag_n  = (r_state == S_RUN);

      case (r_state)
         S_IDLE: begin
            w_par_n = '0;
            w_t_n   = '0;
            if (w_acc) begin
               w_len_n   = cmd.cmd_len;
               w_state_n = S_FETCH;
            end
         end
         S_FETCH: begin
            if (w_ret_vld) begin
               w_par_n   = w_mem_word;
               w_t_n     = '0;
               w_state_n = S_RUN;
            end
         end
         S_RUN: begin
            w_t_n = r_t + BT'(1);
            if (w_acc) begin
               w_sh_full_n = 1'b1;
               w_sh_len_n  = cmd.cmd_len;
            end
            if (w_ret_vld && w_ret_tag) begin
               w_sh_vld_n  = 1'b1;
               w_sh_word_n = w_mem_word;
            end
            // End of segment: chain from shadow, bypass returning data, or fall back
            if (w_last) begin
               w_t_n       = '0;
               w_sh_full_n = 1'b0;
               w_sh_vld_n  = 1'b0;
               if (r_sh_vld) begin
                  w_par_n = r_sh_word;
                  w_len_n = r_sh_len;
               end else if (w_ret_vld && w_ret_tag) begin
                  w_par_n = w_mem_word;
                  w_len_n = r_sh_len;
               end else if (r_sh_full) begin
                  w_par_n   = '0;
                  w_len_n   = r_sh_len;
                  w_state_n = S_FETCH;
               end else if (w_acc) begin
                  w_par_n   = '0;
                  w_len_n   = cmd.cmd_len;
                  w_state_n = S_FETCH;
               end else begin
                  w_par_n   = '0;
                  w_state_n = S_IDLE;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase

      if (stop) begin
         w_state_n   = S_IDLE;
         w_par_n     = '0;
         w_t_n       = '0;
         w_sh_full_n = 1'b0;
         w_sh_vld_n  = 1'b0;
         w_iss_n     = 1'b0;
      end

      w_done_n = (w_state_n == S_RUN) && (w_t_n == w_len_n - BT'(1));
   end

   assign cmd.cmd_ready = w_ready;
   assign mem_addr      = r_mem_addr;
   assign par_dout      = r_par;
   assign t_out         = r_t;
   assign busy          = r_busy;
   assign done          = r_done;
endmodule

// File: tb/tb_mod_dds_seq.sv
// Scoreboard bench for mod_dds_seq: directed segments, expected samples queued at accept time.
module tb_mod_dds_seq;
   localparam int unsigned BT      = 16;
   localparam int unsigned AW      = 10;
   localparam int unsigned MEM_LAT = 2;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic          stop = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [255:0]  mem_dout;
   logic [255:0]  par_dout;
   logic [BT-1:0] t_out;
   logic          busy;
   logic          done;
   logic [255:0]  r_d1, r_d2;
   int            cyc   = 0;
   int            n_vec = 0;
   int            n_err = 0;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      int            t;
      bit            done;
   } exp_t;
   exp_t sb[$];

   mod_dds_seq_if #(.AW(AW), .BT(BT)) cmd_if ();

   mod_dds_seq #(.BT(BT), .AW(AW), .MEM_LAT(MEM_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmd_if),
      .stop     (stop),
      .mem_addr (mem_addr),
      .mem_dout (mem_dout),
      .par_dout (par_dout),
      .t_out    (t_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] word_of(input logic [AW-1:0] a);
      return {8{16'hA5C3, 6'd0, a}};
   endfunction

   // Parameter table with two cycles of read latency
   always @(posedge clk) begin
      r_d1 <= word_of(mem_addr);
      r_d2 <= r_d1;
   end
   assign mem_dout = r_d2;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_seg(input int first, input logic [AW-1:0] a, input int len, input int cnt);
      for (int k = 0; k < cnt; k++) sb.push_back('{first + k, a, k, (k == len - 1)});
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [AW-1:0] a, input int len, output int acc);
      acc = -1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_addr  = a;
      cmd_if.cmd_len   = BT'(len);
      for (int i = 0; i < 300 && acc < 0; i++) begin
         @(negedge clk);
         if (cmd_if.cmd_ready) acc = cyc;
         @(posedge clk);
         #1;
      end
      cmd_if.cmd_valid = 1'b0;
      if (acc < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: addr %0d never accepted", a);
      end
   endtask

   // Monitor: every presented sample must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (par_dout != '0 || done) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_sample: cycle %0d t_out %0d done %0b", cyc, t_out, done);
         end else begin
            e = sb.pop_front();
            if (cyc != e.cyc || par_dout != word_of(e.addr) || t_out != BT'(e.t) || done != e.done) begin
               n_err++;
               $display("FAIL sample: got cycle %0d par %h t %0d done %0b, expected cycle %0d par %h t %0d done %0b",
                        cyc, par_dout[31:0], t_out, done, e.cyc, word_of(e.addr) & 256'hFFFF_FFFF, e.t, e.done);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n1, n2;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_addr  = '0;
      cmd_if.cmd_len   = '0;
      step(3);
      @(negedge clk);
      check("rst_par",   longint'(par_dout == '0), 1);
      check("rst_t",     t_out, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_ready", cmd_if.cmd_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      step(2);

      // Single segment
      send(10'd5, 10, n1);
      push_seg(n1 + 4, 10'd5, 10, 10);
      @(negedge clk);
      check("single_mem_addr", mem_addr, 5);
      check("single_busy",     busy, 1);
      check("single_ready",    cmd_if.cmd_ready, 0);
      wait_until(n1 + 13);
      @(negedge clk);
      check("single_busy_last", busy, 1);
      wait_until(n1 + 14);
      @(negedge clk);
      check("single_busy_end",  busy, 0);
      check("single_ready_end", cmd_if.cmd_ready, 1);
      check("single_t_end",     t_out, 0);
      step(2);

      // Back-to-back, shadow taken on first RUN cycle
      send(10'd3, 100, n1);
      push_seg(n1 + 4, 10'd3, 100, 100);
      send(10'd7, 50, n2);
      check("b2b_accept_cycle", n2, n1 + 4);
      push_seg(n1 + 104, 10'd7, 50, 50);
      @(negedge clk);
      check("b2b_shadow_full_ready", cmd_if.cmd_ready, 0);
      wait_until(n1 + 156);

      // Short chain falls through FETCH
      send(10'd3, 2, n1);
      push_seg(n1 + 4, 10'd3, 2, 2);
      send(10'd4, 8, n2);
      check("short_accept_cycle", n2, n1 + 4);
      push_seg(n1 + 8, 10'd4, 8, 8);
      wait_until(n1 + 6);
      @(negedge clk);
      check("short_gap_busy", busy, 1);
      check("short_gap_par",  longint'(par_dout == '0), 1);
      wait_until(n1 + 18);

      // Zero-length command
      send(10'd9, 0, n1);
      @(negedge clk);
      check("len0_busy",     busy, 0);
      check("len0_ready",    cmd_if.cmd_ready, 1);
      check("len0_mem_addr", mem_addr, 4);
      step(4);
      @(negedge clk);
      check("len0_busy_late", busy, 0);
      step(1);

      // Stop with shadow read outstanding
      send(10'd3, 100, n1);
      push_seg(n1 + 4, 10'd3, 100, 21);
      wait_until(n1 + 22);
      send(10'd7, 50, n2);
      check("stop_shadow_accept", n2, n1 + 22);
      wait_until(n1 + 24);
      stop = 1'b1;
      @(negedge clk);
      check("stop_ready", cmd_if.cmd_ready, 0);
      check("stop_t",     t_out, 20);
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      check("stop_busy", busy, 0);
      check("stop_t0",   t_out, 0);
      check("stop_done", done, 0);
      check("stop_par",  longint'(par_dout == '0), 1);
      step(5);
      @(negedge clk);
      check("stop_busy_late",  busy, 0);
      check("stop_ready_late", cmd_if.cmd_ready, 1);
      step(1);

      // Reset mid-RUN with a command pending
      send(10'd6, 100, n1);
      push_seg(n1 + 4, 10'd6, 100, 6);
      wait_until(n1 + 9);
      rst = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_addr  = 10'd8;
      cmd_if.cmd_len   = BT'(5);
      @(negedge clk);
      check("rst_run_ready", cmd_if.cmd_ready, 0);
      step(1);
      @(negedge clk);
      check("rst_run_par",   longint'(par_dout == '0), 1);
      check("rst_run_t",     t_out, 0);
      check("rst_run_busy",  busy, 0);
      check("rst_run_done",  done, 0);
      check("rst_run_ready", cmd_if.cmd_ready, 0);
      step(1);
      rst = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      check("rst_no_accept", busy, 0);
      step(5);
      @(negedge clk);
      check("rst_busy_late", busy, 0);

      step(3);
      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
